// File: rtl/level_sequencer.sv
// level_sequencer
//   Game-level controller. Each level runs symbol generation (GEN), answer
//   capture (ANSWER), then fires a one-cycle postSig pulse and waits for the
//   post-period block to return levelComplete. Tracks the level number and a
//   saturating score, and declares game over after the last level.
//
//   Optional build macro: POST_TIMEOUT_EN
//     defined   - POST_WAIT gives up after POST_TIMEOUT Tick1Hz pulses and
//                 sets the sticky timeoutErr flag, ending the game.
//     undefined - POST_WAIT waits forever; timeoutErr is tied low.
//
// Ports
//   Clk100M        in   system clock
//   Reset_n        in   asynchronous active-low reset
//   Tick1Hz        in   one-cycle 1 Hz enable pulse
//   startBtn       in   one-cycle start pulse (honoured in IDLE and DONE)
//   answerValid    in   one-cycle pulse, player answer present
//   answerCorrect  in   qualifies answerValid
//   levelComplete  in   one-cycle pulse from the post-period block
//   postSig        out  one-cycle pulse starting the post period
//   genRun         out  high while symbol generation runs
//   level          out  current level, 0-based
//   score          out  count of correct answers (saturating)
//   busy           out  high in every state except IDLE and DONE
//   gameOver       out  high in DONE
//   timeoutErr     out  sticky post-period timeout flag
module level_sequencer #(
  parameter int NUM_LEVELS   = 4,
  parameter int LEVEL_W      = 3,
  parameter int SCORE_W      = 4,
  parameter int GEN_SECONDS  = 5,
  parameter int POST_TIMEOUT = 10
) (
  input  logic               Clk100M,
  input  logic               Reset_n,
  input  logic               Tick1Hz,
  input  logic               startBtn,
  input  logic               answerValid,
  input  logic               answerCorrect,
  input  logic               levelComplete,
  output logic               postSig,
  output logic               genRun,
  output logic [LEVEL_W-1:0] level,
  output logic [SCORE_W-1:0] score,
  output logic               busy,
  output logic               gameOver,
  output logic               timeoutErr
);

  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_GEN       = 3'd1;
  localparam logic [2:0] S_ANSWER    = 3'd2;
  localparam logic [2:0] S_POST_FIRE = 3'd3;
  localparam logic [2:0] S_POST_WAIT = 3'd4;
  localparam logic [2:0] S_DONE      = 3'd5;

  localparam int GEN_W = (GEN_SECONDS > 1) ? $clog2(GEN_SECONDS) : 1;
  localparam logic [GEN_W-1:0]   GEN_LAST   = GEN_W'(GEN_SECONDS - 1);
  localparam logic [LEVEL_W-1:0] LEVEL_LAST = LEVEL_W'(NUM_LEVELS - 1);

  logic [2:0]         state, state_nxt;
  logic [GEN_W-1:0]   gen_cnt, gen_cnt_nxt;
  logic [LEVEL_W-1:0] level_nxt;
  logic [SCORE_W-1:0] score_nxt;
  logic               timeout_hit;
  logic               restart;

  assign restart = startBtn && (state == S_IDLE || state == S_DONE);

`ifdef POST_TIMEOUT_EN
  localparam int TO_W = (POST_TIMEOUT > 1) ? $clog2(POST_TIMEOUT) : 1;
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(POST_TIMEOUT - 1);

  logic [TO_W-1:0] to_cnt;

  assign timeout_hit = (state == S_POST_WAIT) && Tick1Hz && !levelComplete &&
                       (to_cnt == TO_LAST);

  // levelComplete takes priority over a coincident tick and clears the count.
  always_ff @(posedge Clk100M or negedge Reset_n) begin
    if (!Reset_n) begin
      to_cnt     <= '0;
      timeoutErr <= 1'b0;
    end else begin
      if (state != S_POST_WAIT || levelComplete)
        to_cnt <= '0;
      else if (Tick1Hz)
        to_cnt <= to_cnt + 1'b1;

      if (restart)
        timeoutErr <= 1'b0;
      else if (timeout_hit)
        timeoutErr <= 1'b1;
    end
  end
`else
  assign timeout_hit = 1'b0;
  assign timeoutErr  = 1'b0;
`endif

  always_comb begin
    state_nxt   = state;
    gen_cnt_nxt = gen_cnt;
    level_nxt   = level;
    score_nxt   = score;
    case (state)
      S_IDLE, S_DONE: begin
        if (startBtn) begin
          state_nxt   = S_GEN;
          gen_cnt_nxt = '0;
          level_nxt   = '0;
          score_nxt   = '0;
        end
      end
      S_GEN: begin
        if (Tick1Hz) begin
          if (gen_cnt == GEN_LAST) begin
            state_nxt   = S_ANSWER;
            gen_cnt_nxt = '0;
          end else begin
            gen_cnt_nxt = gen_cnt + 1'b1;
          end
        end
      end
      S_ANSWER: begin
        if (answerValid) begin
          state_nxt = S_POST_FIRE;
          if (answerCorrect && score != '1)
            score_nxt = score + 1'b1;
        end
      end
      S_POST_FIRE: state_nxt = S_POST_WAIT;
      S_POST_WAIT: begin
        if (levelComplete) begin
          if (level == LEVEL_LAST) begin
            state_nxt = S_DONE;
          end else begin
            state_nxt   = S_GEN;
            level_nxt   = level + 1'b1;
            gen_cnt_nxt = '0;
          end
        end else if (timeout_hit) begin
          state_nxt = S_DONE;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Status outputs are registered from the next state so they line up with
  // the state register; postSig trails POST_FIRE by one cycle.
  always_ff @(posedge Clk100M or negedge Reset_n) begin
    if (!Reset_n) begin
      state    <= S_IDLE;
      gen_cnt  <= '0;
      level    <= '0;
      score    <= '0;
      postSig  <= 1'b0;
      genRun   <= 1'b0;
      busy     <= 1'b0;
      gameOver <= 1'b0;
    end else begin
      state    <= state_nxt;
      gen_cnt  <= gen_cnt_nxt;
      level    <= level_nxt;
      score    <= score_nxt;
      postSig  <= (state == S_POST_FIRE);
      genRun   <= (state_nxt == S_GEN);
      busy     <= (state_nxt != S_IDLE) && (state_nxt != S_DONE);
      gameOver <= (state_nxt == S_DONE);
    end
  end

endmodule
